response_tx_queue: RTL and testbench
====================================

// Module: response_tx_queue
// PURPOSE
//   Buffers completed sensor responses and feeds them, one byte at a time, to UART_TX.
//   Sits between ResponseHandler (producer) and UART_TX (consumer).
//   - Each response becomes a 2-byte frame: response_code first, then response_data.
//   - Responses are not lost while UART_TX is busy with an earlier frame.
// PARAMETERS
//   DEPTH          4      frame entries in the queue (power of 2, >= 2)
//   ADDR_WIDTH     2      log2(DEPTH)
//   TIMEOUT_CYCLES 65535  max cycles to wait for transmission_done per byte (>= 16)
// PORTS
//   clock              in   1  system clock; all logic on rising edge
//   reset_n            in   1  asynchronous, active-low reset
//   has_response       in   1  1-cycle strobe: response_code/response_data valid
//   response_code      in   8  status byte from ResponseHandler
//   response_data      in   8  payload byte from ResponseHandler
//   transmission_done  in   1  1-cycle strobe from UART_TX: current byte sent
//   has_data           out  1  1-cycle strobe to UART_TX: start sending data_to_send
//   data_to_send       out  8  byte for UART_TX; held stable until transmission_done
//   queue_full         out  1  count == DEPTH
//   queue_empty        out  1  count == 0
//   overflow           out  1  1-cycle pulse: has_response dropped because queue full
//   timeout_error      out  1  1-cycle pulse: frame aborted, transmission_done never arrived
//   dropped_count      out  8  saturating count of dropped responses (overflow pulses)
// BEHAVIOUR
//   Reset (async assert, sync release)
//   - FSM to IDLE; pointers and count 0.
//   - has_data, overflow, timeout_error = 0; data_to_send = 8'h00; dropped_count = 0.
//   - queue_empty = 1; queue_full = 0.
//   - Reset mid-frame discards all queued and in-flight frames.
//   Queue
//   - Circular buffer of DEPTH x 16-bit entries {code, data}.
//   - Write pointer and read pointer wrap modulo DEPTH.
//   - Push on has_response when not full.
//   - Pop when the FSM finishes or aborts the head frame.
//   - has_response while full and no pop this cycle: entry dropped, overflow pulses,
//     dropped_count++ (saturates at 255).
//   - Push and pop in the same cycle, including when full: both happen; count unchanged.
//   FSM: IDLE -> LOAD_CODE -> WAIT_CODE -> LOAD_DATA -> WAIT_DATA -> IDLE
//   - IDLE: if !queue_empty, go to LOAD_CODE.
//   - LOAD_CODE: data_to_send <= head.code, has_data <= 1 (one cycle), go to WAIT_CODE.
//   - WAIT_CODE: on transmission_done, go to LOAD_DATA.
//   - LOAD_DATA: data_to_send <= head.data, has_data pulses, go to WAIT_DATA.
//   - WAIT_DATA: on transmission_done, pop and go to IDLE.
//   Timeout
//   - Per-byte cycle counter, cleared in each LOAD_* state.
//   - If a WAIT_* state lasts TIMEOUT_CYCLES cycles: pop the head frame, timeout_error
//     pulses, go to IDLE.
//   - transmission_done in the same cycle as the timeout wins: normal transition, no error.
//   Timing and strobes
//   - Latency: has_response in cycle N with queue empty and FSM in IDLE gives
//     has_data high in cycle N+3.
//   - Code and data bytes of one frame are never interleaved with another frame.
//   - transmission_done outside the WAIT_* states is ignored.
//   - has_data is never high for 2 consecutive cycles.
//   - All outputs are registered.
// STRUCTURE
//   Shared package (sensor_pkg):
//   - FSM state encoding.
//   - Frame width constant FRAME_W = 16.
//   - Byte order constants CODE_FIRST.
//   Sub-module: sync_fifo (parameterised DEPTH/WIDTH, push/pop/full/empty/count).
//   - Reusable on the RX side later.
//   - FSM, timeout counter and drop counter live in this module.
// TESTING
//   Single frame:
//   - Stimulus: reset, then has_response with code=8'h1F, data=8'hA5; UART_TX model
//     returns transmission_done 10 cycles after each has_data.
//   - Expect: bytes 1F then A5, has_data at N+3, queue_empty=1 at end.
//   Fill to full:
//   - Stimulus: 5 responses back-to-back with done held off, DEPTH=4.
//   - Expect: queue_full=1 after 4; overflow pulse on 5th; dropped_count=1.
//   - Expect: 4 frames later emitted in order.
//   Push and pop together when full:
//   - Stimulus: has_response in the same cycle as the WAIT_DATA done.
//   - Expect: no overflow, count stays 4, new frame emitted last.
//   Timeout:
//   - Stimulus: TIMEOUT_CYCLES=16, never send done.
//   - Expect: timeout_error pulse 16 cycles after has_data; head frame dropped;
//     next frame starts.
//   Reset mid-operation:
//   - Stimulus: assert reset_n=0 during WAIT_CODE with 3 frames queued.
//   - Expect: all outputs at reset values immediately, queue_empty=1, no stray has_data
//     after release.
//   Saturation:
//   - Stimulus: 300 drops while blocked.
//   - Expect: dropped_count stops at 8'hFF.

Source files
------------

// File: rtl/response_tx_queue_pkg.sv
// Shared types and constants for the response transmit path.
package response_tx_queue_pkg;

    localparam int FRAME_W = 16;
    localparam int BYTE_W  = 8;

    // Byte order on the wire: the code byte goes out before the data byte.
    localparam bit CODE_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CODE,
        ST_WAIT_CODE,
        ST_LOAD_DATA,
        ST_WAIT_DATA
    } tx_state_e;

    // One queued response. The code byte occupies the upper half of the entry.
    typedef struct packed {
        logic [BYTE_W-1:0] code;
        logic [BYTE_W-1:0] data;
    } frame_t;

    // Selects the byte of a frame that goes out first or second.
    function automatic logic [BYTE_W-1:0] frame_byte(input frame_t f, input logic first_byte);
        return (first_byte == CODE_FIRST) ? f.code : f.data;
    endfunction

endpackage

// File: rtl/response_tx_queue_if.sv
// Producer/consumer signal bundle around the response transmit queue.
interface response_tx_queue_if;

    logic       has_response;
    logic [7:0] response_code;
    logic [7:0] response_data;
    logic       transmission_done;
    logic       has_data;
    logic [7:0] data_to_send;
    logic       queue_full;
    logic       queue_empty;
    logic       overflow;
    logic       timeout_error;
    logic [7:0] dropped_count;

    // Environment side: ResponseHandler and UART_TX.
    modport master (
        output has_response, response_code, response_data, transmission_done,
        input  has_data, data_to_send, queue_full, queue_empty,
               overflow, timeout_error, dropped_count
    );

    // Queue side.
    modport slave (
        input  has_response, response_code, response_data, transmission_done,
        output has_data, data_to_send, queue_full, queue_empty,
               overflow, timeout_error, dropped_count
    );

endinterface

// File: rtl/response_tx_queue_sync_fifo.sv
// Generic synchronous circular-buffer FIFO with registered full/empty flags.
module sync_fifo #(
    parameter int DEPTH      = 4,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  do_push, do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty_q;
    assign do_push = push && (!full_q || do_pop);

    // Next pointer, occupancy and flag values.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; an entry is only read after it has been written.
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/response_tx_queue.sv
// Queues completed responses and serialises each as a code/data byte pair to UART_TX.
module response_tx_queue
    import response_tx_queue_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clock,
    input  logic                 reset_n,
    response_tx_queue_if.slave   bus
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    tx_state_e           state_q, state_d;
    logic [BYTE_W-1:0]   data_to_send_q, data_to_send_d;
    logic                has_data_q, has_data_d;
    logic                timeout_error_q, timeout_error_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          dropped_count_q, dropped_count_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_WIDTH:0] fifo_count;
    logic [FRAME_W-1:0]  fifo_rd_data;
    frame_t              head, incoming;
    logic                at_capacity, drop;

    assign incoming = '{code: bus.response_code, data: bus.response_data};
    assign head     = frame_t'(fifo_rd_data);

    sync_fifo #(
        .DEPTH      (DEPTH),
        .WIDTH      (FRAME_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (incoming),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A response is dropped only when the queue is full and the head is not leaving.
    assign at_capacity = (fifo_count == DEPTH_C);
    assign drop        = bus.has_response && at_capacity && !fifo_pop;
    assign fifo_push   = bus.has_response && !drop;

    // Transmit sequencer: next state, strobes, per-byte timeout and head release.
    always_comb begin
        state_d         = state_q;
        data_to_send_d  = data_to_send_q;
        has_data_d      = 1'b0;
        timeout_error_d = 1'b0;
        timer_d         = timer_q;
        fifo_pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD_CODE;
            end
            ST_LOAD_CODE: begin
                data_to_send_d = frame_byte(head, 1'b1);
                has_data_d     = 1'b1;
                timer_d        = '0;
                state_d        = ST_WAIT_CODE;
            end
            ST_WAIT_CODE: begin
                // A done arriving in the timeout cycle takes priority over the abort.
                if (bus.transmission_done) begin
                    state_d = ST_LOAD_DATA;
                end else if (timer_q == TIMER_LAST) begin
                    fifo_pop        = 1'b1;
                    timeout_error_d = 1'b1;
                    state_d         = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_LOAD_DATA: begin
                data_to_send_d = frame_byte(head, 1'b0);
                has_data_d     = 1'b1;
                timer_d        = '0;
                state_d        = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (bus.transmission_done) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    fifo_pop        = 1'b1;
                    timeout_error_d = 1'b1;
                    state_d         = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Overflow strobe and saturating drop counter.
    always_comb begin
        overflow_d      = drop;
        dropped_count_d = dropped_count_q;
        if (drop && (dropped_count_q != 8'hFF)) dropped_count_d = dropped_count_q + 8'd1;
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            data_to_send_q  <= 8'h00;
            has_data_q      <= 1'b0;
            timeout_error_q <= 1'b0;
            overflow_q      <= 1'b0;
            dropped_count_q <= 8'h00;
            timer_q         <= '0;
        end else begin
            state_q         <= state_d;
            data_to_send_q  <= data_to_send_d;
            has_data_q      <= has_data_d;
            timeout_error_q <= timeout_error_d;
            overflow_q      <= overflow_d;
            dropped_count_q <= dropped_count_d;
            timer_q         <= timer_d;
        end
    end

    assign bus.has_data      = has_data_q;
    assign bus.data_to_send  = data_to_send_q;
    assign bus.queue_full    = fifo_full;
    assign bus.queue_empty   = fifo_empty;
    assign bus.overflow      = overflow_q;
    assign bus.timeout_error = timeout_error_q;
    assign bus.dropped_count = dropped_count_q;

endmodule

// File: tb/tb_response_tx_queue.sv
// Directed self-checking bench for response_tx_queue (DEPTH=4, TIMEOUT_CYCLES=16).
module tb_response_tx_queue;

    logic clock = 1'b0;
    logic reset_n;

    response_tx_queue_if bus ();

    response_tx_queue #(
        .DEPTH          (4),
        .ADDR_WIDTH     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] got[$];
    int         hd_cycles[$];
    int         ovf_cnt   = 0;
    int         tmo_cnt   = 0;
    int         consec    = 0;
    bit         prev_hd   = 1'b0;
    bit         uart_en   = 1'b1;
    int         uart_cnt  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor plus UART_TX model: done arrives 10 cycles after each has_data.
    always @(negedge clock) begin
        if (bus.has_data === 1'b1) begin
            got.push_back(bus.data_to_send);
            hd_cycles.push_back(cyc);
            if (prev_hd) consec++;
        end
        prev_hd = (bus.has_data === 1'b1);
        if (bus.overflow === 1'b1) ovf_cnt++;
        if (bus.timeout_error === 1'b1) tmo_cnt++;

        bus.transmission_done = 1'b0;
        if (!reset_n) begin
            uart_cnt = 0;
        end else begin
            if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) bus.transmission_done = 1'b1;
            end
            if (bus.has_data === 1'b1 && uart_en) uart_cnt = 10;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] code, input logic [7:0] data);
        bus.has_response  = 1'b1;
        bus.response_code = code;
        bus.response_data = data;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            step();
            k++;
        end
        check("byte_count", 16'(got.size()), 16'(n));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_has_data"},      16'(bus.has_data),      16'h0);
        check({tag, "_data_to_send"},  16'(bus.data_to_send),  16'h00);
        check({tag, "_queue_empty"},   16'(bus.queue_empty),   16'h1);
        check({tag, "_queue_full"},    16'(bus.queue_full),    16'h0);
        check({tag, "_overflow"},      16'(bus.overflow),      16'h0);
        check({tag, "_timeout_error"}, 16'(bus.timeout_error), 16'h0);
        check({tag, "_dropped_count"}, 16'(bus.dropped_count), 16'h00);
    endtask

    function automatic logic [7:0] at(input int idx);
        return (idx < got.size()) ? got[idx] : 8'hXX;
    endfunction

    function automatic int hd_at(input int idx);
        return (idx < hd_cycles.size()) ? hd_cycles[idx] : -1;
    endfunction

    initial begin
        int n0;
        int ovf0;
        int tmo0;
        int k;
        logic [7:0] exp_bytes [10];

        reset_n               = 1'b0;
        bus.has_response      = 1'b0;
        bus.response_code     = 8'h00;
        bus.response_data     = 8'h00;
        bus.transmission_done = 1'b0;

        // Reset state
        repeat (3) step();
        check_reset_values("rst");
        reset_n = 1'b1;
        repeat (2) step();

        // Single frame: 1F then A5, has_data at N+3, data byte 12 cycles after code
        got.delete(); hd_cycles.delete();
        n0 = cyc;
        drive(8'h1F, 8'hA5);
        step();
        bus.has_response = 1'b0;
        check("single_not_empty", 16'(bus.queue_empty), 16'h0);
        wait_bytes(2, 200);
        repeat (15) step();
        check("single_code",     16'(at(0)), 16'h1F);
        check("single_data",     16'(at(1)), 16'hA5);
        check("single_latency",  16'(hd_at(0)), 16'(n0 + 3));
        check("single_byte_gap", 16'(hd_at(1) - hd_at(0)), 16'd12);
        check("single_empty",    16'(bus.queue_empty), 16'h1);
        check("single_no_tmo",   16'(tmo_cnt), 16'd0);

        // Fill to full, then overflow on the fifth response
        got.delete(); hd_cycles.delete();
        ovf0 = ovf_cnt;
        n0   = cyc;
        for (int i = 0; i < 4; i++) begin
            drive(8'(8'h10 + i), 8'(8'h20 + i));
            step();
        end
        check("fill_full",       16'(bus.queue_full),  16'h1);
        check("fill_not_empty",  16'(bus.queue_empty), 16'h0);
        check("fill_no_ovf_yet", 16'(bus.overflow),    16'h0);
        drive(8'h77, 8'h88);
        step();
        bus.has_response = 1'b0;
        check("fill_overflow",   16'(bus.overflow),      16'h1);
        check("fill_dropped",    16'(bus.dropped_count), 16'd1);
        step();
        check("fill_ovf_pulse",  16'(bus.overflow),      16'h0);

        // Push and pop together while full: frame 0 data done lands in cycle N+25
        while (cyc < n0 + 25) step();
        check("pp_full_before",  16'(bus.queue_full), 16'h1);
        drive(8'h55, 8'h66);
        step();
        bus.has_response = 1'b0;
        check("pp_data_hd_cycle", 16'(hd_at(1)), 16'(n0 + 15));
        check("pp_full_after",    16'(bus.queue_full),    16'h1);
        check("pp_no_overflow",   16'(bus.overflow),      16'h0);
        check("pp_dropped_same",  16'(bus.dropped_count), 16'd1);
        wait_bytes(10, 600);
        repeat (15) step();
        exp_bytes = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23, 8'h55, 8'h66};
        for (int i = 0; i < 10; i++) begin
            check($sformatf("order_byte%0d", i), 16'(at(i)), 16'(exp_bytes[i]));
        end
        check("order_empty",     16'(bus.queue_empty), 16'h1);
        check("order_ovf_count", 16'(ovf_cnt - ovf0), 16'd1);

        // Timeout: UART never answers the first frame
        uart_en = 1'b0;
        got.delete(); hd_cycles.delete();
        tmo0 = tmo_cnt;
        n0   = cyc;
        drive(8'hA1, 8'hB1);
        step();
        drive(8'hA2, 8'hB2);
        step();
        bus.has_response = 1'b0;
        k = 0;
        while (bus.timeout_error !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        uart_en = 1'b1;
        check("tmo_seen",       16'(bus.timeout_error), 16'h1);
        check("tmo_code_hd",    16'(hd_at(0)), 16'(n0 + 3));
        check("tmo_delay",      16'(cyc - hd_at(0)), 16'd16);
        step();
        check("tmo_pulse",      16'(bus.timeout_error), 16'h0);
        wait_bytes(3, 300);
        repeat (15) step();
        check("tmo_aborted",    16'(at(0)), 16'hA1);
        check("tmo_next_code",  16'(at(1)), 16'hA2);
        check("tmo_next_data",  16'(at(2)), 16'hB2);
        check("tmo_next_start", 16'(hd_at(1)), 16'(n0 + 21));
        check("tmo_count",      16'(tmo_cnt - tmo0), 16'd1);
        check("tmo_empty",      16'(bus.queue_empty), 16'h1);

        // Reset in WAIT_CODE with three frames queued
        n0 = cyc;
        for (int i = 0; i < 3; i++) begin
            drive(8'(8'hC0 + i), 8'(8'hD0 + i));
            step();
        end
        bus.has_response = 1'b0;
        while (cyc < n0 + 6) step();
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) step();
        reset_n = 1'b1;
        got.delete(); hd_cycles.delete();
        repeat (40) step();
        check("midrst_no_stray", 16'(got.size()), 16'd0);
        check("midrst_empty",    16'(bus.queue_empty), 16'h1);

        // Saturation of dropped_count with the UART silent
        uart_en = 1'b0;
        n0 = cyc;
        drive(8'hE0, 8'hF0);
        while (cyc < n0 + 14) step();
        check("sat_partial",  16'(bus.dropped_count), 16'd10);
        check("sat_ovf_high", 16'(bus.overflow), 16'h1);
        repeat (320) step();
        bus.has_response = 1'b0;
        step();
        check("sat_ff",       16'(bus.dropped_count), 16'hFF);
        step();
        check("sat_ovf_low",  16'(bus.overflow), 16'h0);
        check("sat_hold_ff",  16'(bus.dropped_count), 16'hFF);

        check("has_data_never_back_to_back", 16'(consec), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
